// File: rtl/pcs_blk_sync.sv
// Receive 64b->66b gearbox with sync-header hunting and lock/unlock state machine.
// Define PCS_BLK_SYNC_ERR_CNT_EN to build the saturating invalid-header counter.
module pcs_blk_sync #(
    parameter int LOCK_CNT = 64,
    parameter int WIN_CNT  = 64,
    parameter int BAD_MAX  = 16
) (
    input  logic        RXCLK,
    input  logic        RXRST,
    input  logic [63:0] PMA_DAT,
    input  logic        PMA_VAL,
    input  logic        CSR_ERR_CNT_CLR,
    output logic [63:0] RX_DAT,
    output logic [1:0]  RX_SH,
    output logic        RX_VAL,
    output logic        RX_SYNC,
    output logic        CSR_EXPT_LOCK_LOST,
    output logic [15:0] CSR_BLK_SYNC_ERR_CNT
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_CNT + 1);
    localparam int BW = $clog2(BAD_MAX + 1);

    typedef enum logic [1:0] {
        HUNT,
        SLIP_WAIT,
        LOCKED
    } state_t;

    state_t         state, state_nxt;
    logic [129:0]   gb_buf, gb_nxt;
    logic [7:0]     fill, fill_nxt;
    logic [7:0]     need, used;
    logic           slip_pend;
    logic           do_ext;
    logic [65:0]    blk;
    logic           hdr_ok;
    logic [GW-1:0]  good_cnt, good_nxt, good_inc;
    logic [WW-1:0]  win_cnt, win_nxt, win_inc;
    logic [BW-1:0]  bad_cnt, bad_nxt, bad_inc;
    logic           slip_set;
    logic           lost_nxt;
    logic           bad_eval;

    // A pending slip makes the next extraction drop the oldest bit, so it needs one extra bit.
    always_comb begin
        need     = slip_pend ? 8'd67 : 8'd66;
        do_ext   = (fill >= need);
        used     = do_ext ? need : 8'd0;
        blk      = slip_pend ? gb_buf[66:1] : gb_buf[65:0];
        hdr_ok   = blk[1] ^ blk[0];
        gb_nxt   = gb_buf >> used;
        if (PMA_VAL) begin
            gb_nxt = gb_nxt | ({66'd0, PMA_DAT} << (fill - used));
        end
        fill_nxt = (fill - used) + (PMA_VAL ? 8'd64 : 8'd0);
    end

    always_ff @(posedge RXCLK or posedge RXRST) begin
        if (RXRST) begin
            gb_buf    <= '0;
            fill      <= 8'd0;
            slip_pend <= 1'b0;
        end else begin
            gb_buf    <= gb_nxt;
            fill      <= fill_nxt;
            slip_pend <= slip_set | (slip_pend & ~do_ext);
        end
    end

    always_ff @(posedge RXCLK or posedge RXRST) begin
        if (RXRST) begin
            state    <= HUNT;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            win_cnt  <= win_nxt;
            bad_cnt  <= bad_nxt;
        end
    end

    // Headers are judged only on extraction; the slipped block in SLIP_WAIT is judged as in HUNT.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        win_nxt   = win_cnt;
        bad_nxt   = bad_cnt;
        slip_set  = 1'b0;
        lost_nxt  = 1'b0;
        bad_eval  = 1'b0;
        good_inc  = good_cnt + GW'(1);
        win_inc   = win_cnt + WW'(1);
        bad_inc   = bad_cnt + BW'(1);
        if (do_ext) begin
            unique case (state)
                HUNT, SLIP_WAIT: begin
                    if (state == HUNT || slip_pend) begin
                        if (hdr_ok) begin
                            if (good_inc == GW'(LOCK_CNT)) begin
                                state_nxt = LOCKED;
                                good_nxt  = '0;
                                win_nxt   = '0;
                                bad_nxt   = '0;
                            end else begin
                                state_nxt = HUNT;
                                good_nxt  = good_inc;
                            end
                        end else begin
                            bad_eval  = 1'b1;
                            slip_set  = 1'b1;
                            good_nxt  = '0;
                            state_nxt = SLIP_WAIT;
                        end
                    end
                end
                LOCKED: begin
                    bad_eval = ~hdr_ok;
                    if (!hdr_ok && bad_inc == BW'(BAD_MAX)) begin
                        lost_nxt  = 1'b1;
                        slip_set  = 1'b1;
                        state_nxt = SLIP_WAIT;
                        good_nxt  = '0;
                        win_nxt   = '0;
                        bad_nxt   = '0;
                    end else if (win_inc == WW'(WIN_CNT)) begin
                        win_nxt = '0;
                        bad_nxt = '0;
                    end else begin
                        win_nxt = win_inc;
                        bad_nxt = hdr_ok ? bad_cnt : bad_inc;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    // Block fields are held between strobes; only RX_VAL marks a new block.
    always_ff @(posedge RXCLK or posedge RXRST) begin
        if (RXRST) begin
            RX_DAT             <= 64'd0;
            RX_SH              <= 2'd0;
            RX_VAL             <= 1'b0;
            CSR_EXPT_LOCK_LOST <= 1'b0;
        end else begin
            RX_VAL             <= do_ext;
            CSR_EXPT_LOCK_LOST <= lost_nxt;
            if (do_ext) begin
                RX_DAT <= blk[65:2];
                RX_SH  <= blk[1:0];
            end
        end
    end

    assign RX_SYNC = (state == LOCKED);

`ifdef PCS_BLK_SYNC_ERR_CNT_EN
    logic [15:0] err_cnt;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge RXCLK or posedge RXRST) begin
        if (RXRST) begin
            err_cnt <= 16'd0;
        end else if (CSR_ERR_CNT_CLR) begin
            err_cnt <= 16'd0;
        end else if (bad_eval && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign CSR_BLK_SYNC_ERR_CNT = err_cnt;
`else
    logic unused_err_cnt;

    assign unused_err_cnt       = &{1'b0, CSR_ERR_CNT_CLR, bad_eval};
    assign CSR_BLK_SYNC_ERR_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_pcs_blk_sync.sv
// Scoreboard bench for pcs_blk_sync: blocks are serialised into a bit queue and expected
// results queued alongside; each RX_VAL pops one expectation.
module tb_pcs_blk_sync;

    logic        RXCLK = 1'b0;
    logic        RXRST;
    logic [63:0] PMA_DAT;
    logic        PMA_VAL;
    logic        CSR_ERR_CNT_CLR;
    logic [63:0] RX_DAT;
    logic [1:0]  RX_SH;
    logic        RX_VAL;
    logic        RX_SYNC;
    logic        CSR_EXPT_LOCK_LOST;
    logic [15:0] CSR_BLK_SYNC_ERR_CNT;

    always #5 RXCLK = ~RXCLK;

    pcs_blk_sync dut (
        .RXCLK                (RXCLK),
        .RXRST                (RXRST),
        .PMA_DAT              (PMA_DAT),
        .PMA_VAL              (PMA_VAL),
        .CSR_ERR_CNT_CLR      (CSR_ERR_CNT_CLR),
        .RX_DAT               (RX_DAT),
        .RX_SH                (RX_SH),
        .RX_VAL               (RX_VAL),
        .RX_SYNC              (RX_SYNC),
        .CSR_EXPT_LOCK_LOST   (CSR_EXPT_LOCK_LOST),
        .CSR_BLK_SYNC_ERR_CNT (CSR_BLK_SYNC_ERR_CNT)
    );

    typedef struct {
        logic [63:0] dat;
        logic [1:0]  sh;
        bit          chkDat;
        bit          sync;
        bit          lost;
    } expRec_t;

    expRec_t expQ[$];
    bit      bitQ[$];
    expRec_t rec;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc, pmaCnt, secondPmaCyc, firstValCyc, lowCnt, valCnt, lostCnt, blkIdx;
    bit driveEn = 0;
    bit gapMode = 0;
    bit zeroMode = 0;
    bit measLow = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic appendBlock(input logic [63:0] dat, input logic [1:0] sh);
        bitQ.push_back(sh[0]);
        bitQ.push_back(sh[1]);
        for (int i = 0; i < 64; i++) bitQ.push_back(dat[i]);
    endtask

    task automatic applyStimulus(input logic [63:0] dat, input logic [1:0] sh,
                                 input bit chkDat, input bit sync, input bit lost);
        expRec_t r;
        appendBlock(dat, sh);
        r.dat = dat;
        r.sh = sh;
        r.chkDat = chkDat;
        r.sync = sync;
        r.lost = lost;
        expQ.push_back(r);
    endtask

    // Driver: serialises the bit queue; valid filler blocks keep the stream going after the test data.
    initial begin
        PMA_VAL = 1'b0;
        PMA_DAT = 64'd0;
        forever begin
            @(negedge RXCLK);
            if (driveEn && (!gapMode || $urandom_range(1, 0) == 1)) begin
                if (zeroMode) begin
                    PMA_DAT = 64'd0;
                end else begin
                    while (bitQ.size() < 64) appendBlock({$urandom(), $urandom()}, 2'b01);
                    for (int i = 0; i < 64; i++) PMA_DAT[i] = bitQ.pop_front();
                end
                PMA_VAL = 1'b1;
            end else begin
                PMA_VAL = 1'b0;
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge RXCLK);
            #1;
            cyc++;
            if (PMA_VAL) begin
                pmaCnt++;
                if (pmaCnt == 2) secondPmaCyc = cyc;
            end
            if (CSR_EXPT_LOCK_LOST) lostCnt++;
            if (RX_VAL) begin
                valCnt++;
                if (firstValCyc < 0) firstValCyc = cyc;
            end
            if (measLow && firstValCyc >= 0 && cyc - firstValCyc < 99 && !RX_VAL) lowCnt++;
            if (RX_VAL && expQ.size() > 0) begin
                rec = expQ.pop_front();
                if (rec.chkDat) begin
                    checkOutput($sformatf("dat[%0d]", blkIdx), RX_DAT, rec.dat);
                    checkOutput($sformatf("sh[%0d]", blkIdx), 64'(RX_SH), 64'(rec.sh));
                end else begin
                    checkOutput($sformatf("huntHdrValid[%0d]", blkIdx), 64'(RX_SH[1] ^ RX_SH[0]), 64'd0);
                end
                checkOutput($sformatf("sync[%0d]", blkIdx), 64'(RX_SYNC), 64'(rec.sync));
                checkOutput($sformatf("lockLost[%0d]", blkIdx), 64'(CSR_EXPT_LOCK_LOST), 64'(rec.lost));
                blkIdx++;
            end
        end
    end

    task automatic resetDut();
        driveEn = 0;
        gapMode = 0;
        zeroMode = 0;
        measLow = 0;
        RXRST = 1'b1;
        bitQ.delete();
        expQ.delete();
        repeat (3) @(posedge RXCLK);
        @(negedge RXCLK);
        RXRST = 1'b0;
        cyc = 0;
        pmaCnt = 0;
        secondPmaCyc = -1;
        firstValCyc = -1;
        lowCnt = 0;
        valCnt = 0;
        lostCnt = 0;
        blkIdx = 0;
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(posedge RXCLK);
            n++;
        end
        #2;
        checkOutput(tag, 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dat"}, RX_DAT, 64'd0);
        checkOutput({tag, "_sh"}, 64'(RX_SH), 64'd0);
        checkOutput({tag, "_val"}, 64'(RX_VAL), 64'd0);
        checkOutput({tag, "_sync"}, 64'(RX_SYNC), 64'd0);
        checkOutput({tag, "_lost"}, 64'(CSR_EXPT_LOCK_LOST), 64'd0);
        checkOutput({tag, "_err"}, 64'(CSR_BLK_SYNC_ERR_CNT), 64'd0);
    endtask

    initial begin
        int n;
        bit bad;
        RXRST = 1'b0;
        CSR_ERR_CNT_CLR = 1'b0;
        #2 RXRST = 1'b1;
        #1;
        checkAllZero("reset");
        resetDut();

        // Aligned stream: lock on block 64, in-order payloads, one idle cycle per 33.
        for (int i = 0; i < 100; i++) applyStimulus(64'(i), 2'b01, 1, i >= 63, 0);
        measLow = 1;
        driveEn = 1;
        waitDrain(400, "alignedDrain");
        while (cyc - firstValCyc < 100) @(posedge RXCLK);
        #2;
        checkOutput("valLowPer99", 64'(lowCnt), 64'd3);
        checkOutput("firstValLatency", 64'(firstValCyc - secondPmaCyc), 64'd1);
        checkOutput("alignedLostCnt", 64'(lostCnt), 64'd0);

        // Misaligned by 17 bits: 17 hunting blocks with bad headers, then lock.
        resetDut();
        for (int i = 0; i < 17; i++) bitQ.push_back(1'b0);
        for (int i = 0; i < 100; i++) applyStimulus({16'hFFFF, 48'(i)}, 2'b01, i >= 17, i >= 80, 0);
        driveEn = 1;
        waitDrain(400, "misalignDrain");
        checkOutput("misalignSync", 64'(RX_SYNC), 64'd1);
`ifdef PCS_BLK_SYNC_ERR_CNT_EN
        checkOutput("misalignErrCnt", 64'(CSR_BLK_SYNC_ERR_CNT), 64'd17);
`else
        checkOutput("misalignErrCnt", 64'(CSR_BLK_SYNC_ERR_CNT), 64'd0);
`endif

        // Lock loss: 16 bad headers inside one window, then bounded wait for relock.
        resetDut();
        for (int i = 0; i <= 104; i++) begin
            bad = (i >= 74) && ((i - 74) % 2 == 0);
            applyStimulus(64'(i) ^ 64'h0123_4567_89AB_CDEF, bad ? 2'b11 : 2'b01, 1,
                          i >= 63 && i < 104, i == 104);
        end
        driveEn = 1;
        waitDrain(400, "lossDrain");
        checkOutput("lossLostCnt", 64'(lostCnt), 64'd1);
        n = 0;
        do begin
            @(posedge RXCLK);
            #2;
            n++;
        end while (!RX_SYNC && n < 3000);
        checkOutput("relock", 64'(RX_SYNC), 64'd1);
        checkOutput("lossLostOnce", 64'(lostCnt), 64'd1);

        // Tolerated errors: 15 bad per window, back to back across window edges.
        resetDut();
        for (int i = 0; i < 320; i++) begin
            bad = 0;
            if (i >= 64) begin
                bad = (((i - 64) / 64) % 2 == 0) ? ((i - 64) % 64 >= 49) : ((i - 64) % 64 < 15);
            end
            applyStimulus(64'(i) * 64'd977, bad ? 2'b11 : 2'b01, 1, i >= 63, 0);
        end
        driveEn = 1;
        waitDrain(600, "tolerDrain");
        checkOutput("tolerSync", 64'(RX_SYNC), 64'd1);
        checkOutput("tolerLostCnt", 64'(lostCnt), 64'd0);

        // Random gaps on PMA_VAL, then asynchronous reset while locked.
        resetDut();
        for (int i = 0; i < 80; i++) applyStimulus(64'(i) ^ 64'hA5A5_0000_5A5A_FFFF, 2'b01, 1, i >= 63, 0);
        gapMode = 1;
        driveEn = 1;
        waitDrain(800, "gapDrain");
        checkOutput("gapPreRstSync", 64'(RX_SYNC), 64'd1);
        @(posedge RXCLK);
        #3;
        RXRST = 1'b1;
        #1;
        checkAllZero("midRst");
        resetDut();
        for (int i = 0; i < 70; i++) applyStimulus(64'(i) + 64'h1000, 2'b01, 1, i >= 63, 0);
        driveEn = 1;
        waitDrain(400, "relockDrain");

        // Error counter under a stream of all-invalid headers.
        resetDut();
        zeroMode = 1;
        driveEn = 1;
`ifdef PCS_BLK_SYNC_ERR_CNT_EN
        n = 0;
        while (valCnt < 70000 && n < 80000) begin
            @(posedge RXCLK);
            n++;
        end
        #2;
        checkOutput("errSatVals", 64'(valCnt >= 70000), 64'd1);
        checkOutput("errSat", 64'(CSR_BLK_SYNC_ERR_CNT), 64'hFFFF);
`else
        repeat (300) @(posedge RXCLK);
        #2;
        checkOutput("errOff", 64'(CSR_BLK_SYNC_ERR_CNT), 64'd0);
`endif
        checkOutput("zeroSync", 64'(RX_SYNC), 64'd0);
        @(negedge RXCLK);
        CSR_ERR_CNT_CLR = 1'b1;
        @(posedge RXCLK);
        #1;
        checkOutput("errClr", 64'(CSR_BLK_SYNC_ERR_CNT), 64'd0);
        @(negedge RXCLK);
        CSR_ERR_CNT_CLR = 1'b0;
        repeat (10) @(posedge RXCLK);
        #1;
`ifdef PCS_BLK_SYNC_ERR_CNT_EN
        checkOutput("errRecount", 64'(CSR_BLK_SYNC_ERR_CNT != 16'd0), 64'd1);
`else
        checkOutput("errStaysOff", 64'(CSR_BLK_SYNC_ERR_CNT), 64'd0);
`endif
        driveEn = 0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
